// File: rtl/ps2_cmd_scheduler.sv
// Round-robin scheduler sharing one PS/2 host-to-device path among NREQ requesters.
// Sends cmd (+ optional arg) bytes, waits for ACK, retries on RESEND/timeout, forwards other rx bytes.
module ps2_cmd_scheduler #(
    parameter int         NREQ        = 3,
    parameter int         ACK_TIMEOUT = 50000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] ACK_BYTE    = 8'hFA,
    parameter logic [7:0] RESEND_BYTE = 8'hFE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_cmd,
    input  logic [8*NREQ-1:0] req_arg,
    input  logic [NREQ-1:0]   req_has_arg,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_write,
    input  logic              tx_done_tick,
    input  logic [7:0]        rx_data,
    input  logic              rx_done_tick,
    output logic [7:0]        scan_data,
    output logic              scan_valid
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [TW-1:0] T_LOAD = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_SEND_CMD     = 3'd1,
        S_WAIT_TX_CMD  = 3'd2,
        S_WAIT_ACK_CMD = 3'd3,
        S_SEND_ARG     = 3'd4,
        S_WAIT_TX_ARG  = 3'd5,
        S_WAIT_ACK_ARG = 3'd6
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_idx;
    logic [7:0]      r_cmd;
    logic [7:0]      r_arg;
    logic            r_has_arg;
    logic [7:0]      r_tx_data;
    logic            r_tx_write;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic [TW-1:0]   r_timer;
    logic [RW-1:0]   r_retry;

    logic            w_found;
    logic [PW-1:0]   w_sel;
    logic [PW-1:0]   w_cand;
    logic [NREQ-1:0] w_grant;
    logic            w_in_tx;
    logic            w_in_ack;
    logic            w_is_ack;
    logic            w_is_resend;
    logic            w_timeout;
    logic            w_fail;
    state_t          w_resend_st;

    // Round-robin search: first pending request at or after r_rr_ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant is combinational so the requester sees it in the capture cycle
    always_comb begin
        w_grant = '0;
        if (reset && (r_state == S_IDLE) && w_found) begin
            w_grant[w_sel] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    assign w_in_tx     = (r_state == S_WAIT_TX_CMD) || (r_state == S_WAIT_TX_ARG);
    assign w_in_ack    = (r_state == S_WAIT_ACK_CMD) || (r_state == S_WAIT_ACK_ARG);
    assign w_is_ack    = rx_done_tick && w_in_ack && (rx_data == ACK_BYTE);
    assign w_is_resend = rx_done_tick && w_in_ack && (rx_data == RESEND_BYTE);
    // An rx byte arriving on the expiry cycle suppresses the timeout
    assign w_timeout   = (r_timer == '0) && !rx_done_tick;
    assign w_fail      = (w_in_tx && !tx_done_tick && w_timeout) ||
                         (w_in_ack && (w_is_resend || w_timeout));
    assign w_resend_st = ((r_state == S_WAIT_TX_CMD) || (r_state == S_WAIT_ACK_CMD)) ?
                         S_SEND_CMD : S_SEND_ARG;

    // Request sequencing FSM with registered pulse outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_idx      <= '0;
            r_cmd      <= 8'h00;
            r_arg      <= 8'h00;
            r_has_arg  <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_write <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
            r_timer    <= '0;
            r_retry    <= '0;
        end else begin
            r_tx_write <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx     <= w_sel;
                        r_cmd     <= req_cmd[8*w_sel +: 8];
                        r_arg     <= req_arg[8*w_sel +: 8];
                        r_has_arg <= req_has_arg[w_sel];
                        r_rr_ptr  <= (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
                        r_retry   <= '0;
                        r_state   <= S_SEND_CMD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SEND_CMD, S_SEND_ARG: begin
                    r_tx_data  <= (r_state == S_SEND_CMD) ? r_cmd : r_arg;
                    r_tx_write <= 1'b1;
                    r_timer    <= T_LOAD;
                    r_state    <= (r_state == S_SEND_CMD) ? S_WAIT_TX_CMD : S_WAIT_TX_ARG;
                end
                S_WAIT_TX_CMD, S_WAIT_TX_ARG, S_WAIT_ACK_CMD, S_WAIT_ACK_ARG: begin
                    if (w_in_tx && tx_done_tick) begin
                        r_timer <= T_LOAD;
                        r_state <= (r_state == S_WAIT_TX_CMD) ? S_WAIT_ACK_CMD : S_WAIT_ACK_ARG;
                    end else if (w_is_ack) begin
                        if ((r_state == S_WAIT_ACK_CMD) && r_has_arg) begin
                            r_state <= S_SEND_ARG;
                        end else begin
                            r_done[r_idx] <= 1'b1;
                            r_state       <= S_IDLE;
                        end
                    end else if (w_fail) begin
                        if (r_retry < R_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= w_resend_st;
                        end else begin
                            r_err[r_idx] <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end else if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant      = w_grant;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = (r_state != S_IDLE);
    assign tx_data    = r_tx_data;
    assign tx_write   = r_tx_write;
    assign scan_data  = rx_data;
    assign scan_valid = rx_done_tick && !(w_is_ack || w_is_resend);
endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: directed scenarios plus randomized traffic against a
// transaction-level reference model compared every cycle on the falling clock edge.
module tb_ps2_cmd_scheduler;
    localparam int NREQ = 3;
    localparam int TO   = 16;
    localparam int MR   = 3;
    localparam logic [7:0] ACKB = 8'hFA;
    localparam logic [7:0] RSNB = 8'hFE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0] req = '0, req_has_arg = '0;
    logic [8*NREQ-1:0] req_cmd = '0, req_arg = '0;
    logic tx_done_tick = 1'b0, rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [NREQ-1:0] grant, done, err;
    logic busy, tx_write, scan_valid;
    logic [7:0] tx_data, scan_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_cmd_scheduler #(.NREQ(NREQ), .ACK_TIMEOUT(TO), .MAX_RETRY(MR),
                        .ACK_BYTE(ACKB), .RESEND_BYTE(RSNB)) dut (
        .clk(clk), .reset(rst_n), .req(req), .req_cmd(req_cmd), .req_arg(req_arg),
        .req_has_arg(req_has_arg), .grant(grant), .done(done), .err(err), .busy(busy),
        .tx_data(tx_data), .tx_write(tx_write), .tx_done_tick(tx_done_tick),
        .rx_data(rx_data), .rx_done_tick(rx_done_tick), .scan_data(scan_data),
        .scan_valid(scan_valid));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction view) ----------------
    bit m_active;
    int m_who, m_pos, m_nbytes, m_step, m_elapsed, m_tries, m_rr;
    logic [7:0] m_bytes [2];
    logic [7:0] e_tx_data;
    bit e_tx_write;
    logic [NREQ-1:0] e_done, e_err;

    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        for (int k = 0; k < NREQ; k++)
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_fail();
        if (m_tries < MR) begin
            m_tries++;
            m_step = 0;
        end else begin
            e_err[m_who] = 1'b1;
            m_active = 0;
        end
    endtask

    // step: 0 byte about to go out, 1 waiting for transmit, 2 waiting for reply
    task automatic model_step();
        int p;
        e_tx_write = 0; e_done = '0; e_err = '0;
        if (!m_active) begin
            p = pick(req, m_rr);
            if (p >= 0) begin
                m_active = 1; m_who = p; m_pos = 0; m_tries = 0; m_step = 0;
                m_bytes[0] = req_cmd[8*p +: 8]; m_bytes[1] = req_arg[8*p +: 8];
                m_nbytes = req_has_arg[p] ? 2 : 1;
                m_rr = (p + 1) % NREQ;
            end
        end else if (m_step == 0) begin
            e_tx_data = m_bytes[m_pos]; e_tx_write = 1; m_step = 1; m_elapsed = 0;
        end else if (m_step == 1 && tx_done_tick) begin
            m_step = 2; m_elapsed = 0;
        end else if (m_step == 2 && rx_done_tick && rx_data == ACKB) begin
            m_pos++;
            if (m_pos == m_nbytes) begin e_done[m_who] = 1'b1; m_active = 0; end
            else m_step = 0;
        end else if (m_step == 2 && rx_done_tick && rx_data == RSNB) begin
            model_fail();
        end else if (rx_done_tick) begin
            if (m_elapsed < TO - 1) m_elapsed++;
        end else if (m_elapsed == TO - 1) begin
            model_fail();
        end else begin
            m_elapsed++;
        end
    endtask

    // Compare DUT against model mid-cycle, then advance the model for the next edge
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        int p;
        if (!rst_n) begin
            m_active = 0; m_rr = 0; e_tx_data = 8'h00; e_tx_write = 0; e_done = '0; e_err = '0;
        end
        eg = '0;
        if (rst_n && !m_active) begin
            p = pick(req, m_rr);
            if (p >= 0) eg[p] = 1'b1;
        end
        check("m_grant", grant, eg);
        check("m_busy", busy, m_active);
        check("m_tx_write", tx_write, e_tx_write);
        check("m_tx_data", tx_data, e_tx_data);
        check("m_done", done, e_done);
        check("m_err", err, e_err);
        check("m_scan_valid", scan_valid,
              rx_done_tick && !(m_active && m_step == 2 && (rx_data == ACKB || rx_data == RSNB)));
        check("m_scan_data", scan_data, rx_data);
        if (rst_n) model_step();
    end

    // ---------------- directed helpers ----------------
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic wait_txw(input string nm, output logic [7:0] d);
        int n = 0;
        while (!tx_write && n < 60) begin cyc(); n++; end
        check({nm, "_txw_seen"}, tx_write, 1'b1);
        d = tx_data;
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b; rx_done_tick = 1'b1; cyc(); rx_done_tick = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] c, input logic [7:0] a, input logic h);
        req_cmd[8*i +: 8] = c; req_arg[8*i +: 8] = a; req_has_arg[i] = h; req[i] = 1'b1;
    endtask

    task automatic serve_one(output int who);
        logic [7:0] d;
        who = -1;
        for (int n = 0; n < 50 && who < 0; n++) begin
            #1;
            for (int i = NREQ - 1; i >= 0; i--) if (grant[i]) who = i;
            cyc();
        end
        if (who < 0) begin check("serve_grant_timeout", 0, 1); return; end
        req[who] = 1'b0;
        for (int b = 0; b < 4 && busy; b++) begin
            wait_txw("serve", d); pulse_tx_done(); rx_byte(ACKB);
        end
        check("serve_done", done, 32'(1) << who);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        int who, sends, n, txc, rxc, r;
        logic [NREQ-1:0] g;
        logic txw;
        logic [7:0] fe3 [4];

        repeat (3) cyc();
        #1;
        check("rst_busy", busy, 1'b0); check("rst_tx_write", tx_write, 1'b0);
        check("rst_tx_data", tx_data, 8'h00); check("rst_done", done, 3'b000);
        check("rst_grant", grant, 3'b000);
        rst_n = 1'b1; cyc();

        // T1: single command, no argument
        set_req(0, 8'hF4, 8'h00, 1'b0); #1;
        check("t1_grant", grant, 3'b001);
        cyc(); req[0] = 1'b0;
        wait_txw("t1", d); check("t1_tx_data", d, 8'hF4);
        pulse_tx_done();
        rx_data = ACKB; rx_done_tick = 1'b1; #1;
        check("t1_scan_valid", scan_valid, 1'b0);
        cyc(); rx_done_tick = 1'b0;
        check("t1_done", done, 3'b001);
        cyc(); check("t1_done_once", done, 3'b000);

        // T2: command with argument
        set_req(1, 8'hED, 8'h07, 1'b1); #1;
        check("t2_grant", grant, 3'b010);
        cyc(); req[1] = 1'b0;
        wait_txw("t2a", d); check("t2_cmd", d, 8'hED);
        pulse_tx_done(); rx_byte(ACKB);
        check("t2_no_early_done", done, 3'b000);
        wait_txw("t2b", d); check("t2_arg", d, 8'h07);
        pulse_tx_done(); rx_byte(ACKB);
        check("t2_done", done, 3'b010);

        // T3: round-robin order from reset
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'hF4, 8'h00, 1'b0);
        for (int k = 0; k < NREQ; k++) begin serve_one(who); check("t3_order", who, k); end
        set_req(0, 8'hF4, 8'h00, 1'b0); set_req(2, 8'hF5, 8'h00, 1'b0);
        serve_one(who); check("t3_101_first", who, 0);
        serve_one(who); check("t3_101_second", who, 2);

        // T4: resend handling and retry exhaustion
        fe3[0] = RSNB; fe3[1] = RSNB; fe3[2] = ACKB;
        set_req(0, 8'hF4, 8'h00, 1'b0); cyc(); req[0] = 1'b0;
        sends = 0;
        for (int k = 0; k < 3; k++) begin
            wait_txw("t4", d); sends++; check("t4_resend_byte", d, 8'hF4);
            pulse_tx_done(); rx_byte(fe3[k]);
        end
        check("t4_sends", sends, 3); check("t4_done", done, 3'b001);
        set_req(0, 8'hF4, 8'h00, 1'b0); cyc(); req[0] = 1'b0;
        sends = 0;
        for (int k = 0; k < 4; k++) begin
            wait_txw("t4e", d); sends++; pulse_tx_done(); rx_byte(RSNB);
        end
        check("t4e_sends", sends, 4); check("t4e_err", err, 3'b001);
        check("t4e_no_done", done, 3'b000); check("t4e_idle", busy, 1'b0);

        // T5: ack timeout, then a scan byte during transmit wait
        set_req(2, 8'hF4, 8'h00, 1'b0); cyc(); req[2] = 1'b0;
        wait_txw("t5", d); pulse_tx_done();
        n = 0;
        while (!tx_write && n < 40) begin cyc(); n++; end
        check("t5_timeout_cycles", n, 17);
        rx_data = 8'h1C; rx_done_tick = 1'b1; #1;
        check("t5_scan_valid", scan_valid, 1'b1); check("t5_scan_data", scan_data, 8'h1C);
        cyc(); rx_done_tick = 1'b0;
        pulse_tx_done(); rx_byte(ACKB);
        check("t5_done", done, 3'b100);

        // T6: reset while waiting for the argument ack
        set_req(2, 8'hED, 8'h55, 1'b1); cyc(); req[2] = 1'b0;
        wait_txw("t6a", d); pulse_tx_done(); rx_byte(ACKB);
        wait_txw("t6b", d); pulse_tx_done();
        rst_n = 1'b0; #1;
        check("t6_busy", busy, 1'b0); check("t6_tx_write", tx_write, 1'b0);
        check("t6_tx_data", tx_data, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cyc(); check("t6_no_done_err", {done, err}, 6'b000000);
        end
        rst_n = 1'b1; cyc();
        set_req(1, 8'hF3, 8'h00, 1'b0);
        serve_one(who); check("t6_next_who", who, 1);

        // Randomized traffic: requesters, transceiver and device with random latencies
        txc = -1; rxc = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); g = grant; txw = tx_write;
            @(posedge clk); #2;
            tx_done_tick = 1'b0; rx_done_tick = 1'b0;
            rst_n = !(c >= 1500 && c < 1503);
            if (!rst_n) begin txc = -1; rxc = -1; end
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 9) == 0)
                    set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
            end
            if (txc == 0) begin
                tx_done_tick = 1'b1; txc = -1; rxc = int'($urandom_range(0, 4));
            end else if (txc > 0) txc--;
            if (txw) txc = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            if (rxc == 0) begin
                r = int'($urandom_range(0, 19)); rxc = -1;
                if (r < 14) rx_data = ACKB;
                else if (r < 17) rx_data = RSNB;
                else if (r < 19) begin rx_data = 8'($urandom); rxc = 2; end
                rx_done_tick = (r < 19);
            end else if (rxc > 0) rxc--;
            else if ($urandom_range(0, 19) == 0) begin
                rx_data = 8'($urandom); rx_done_tick = 1'b1;
            end
        end
        tx_done_tick = 1'b0; rx_done_tick = 1'b0; req = '0;
        repeat (5) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
